// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// FSM encoding, reset constants and the owner-index width helper.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam state_t RST_STATE   = IDLE;
  localparam logic   RST_Q_VALID = 1'b0;
  localparam logic   RST_BUSY    = 1'b0;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register: requests, write data, and the
// arbiter's ack / register / status returns.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         q;
  logic                      q_valid;
  logic [IDX_W-1:0]          owner;
  logic                      busy;

  modport master (output req, wdata, input ack, q, q_valid, owner, busy);
  modport slave  (input req, wdata, output ack, q, q_valid, owner, busy);

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: rotate req so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_REQ - 1);
  localparam logic [IDX_W:0] N    = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    // Explicit wrap so non-power-of-two NUM_REQ stays in range.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum > LAST) sum = sum - N;
    winner = sum[IDX_W-1:0];
  end

  assign any_req = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer: the single writer of a shared DATA_W-bit
// register, IDLE -> GRANT -> ACK per write, one-cycle ack to the winner.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic              clk,
  input logic              rst,
  shared_reg_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  state_t             state, nxt;
  logic [IDX_W-1:0]   ptr, winner, ptr_nxt;
  logic               any_req, owner_req;
  logic               owner_ld, q_ld, ptr_adv;
  logic [NUM_REQ-1:0] ack_nxt;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_req = bus.req[bus.owner];
  assign ptr_nxt   = (bus.owner == LAST) ? '0 : bus.owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = GRANT;
      GRANT:   nxt = owner_req ? ACK : IDLE;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // A dropped request in GRANT is an abort: nothing is written, ptr stays.
  always_comb begin
    owner_ld = 1'b0;
    q_ld     = 1'b0;
    ptr_adv  = 1'b0;
    ack_nxt  = '0;
    case (state)
      IDLE:  owner_ld = any_req;
      GRANT: begin
        if (owner_req) begin
          q_ld             = 1'b1;
          ack_nxt[bus.owner] = 1'b1;
        end
      end
      ACK:     ptr_adv = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ack     <= '0;
      bus.q       <= '0;
      bus.q_valid <= RST_Q_VALID;
      bus.owner   <= '0;
      bus.busy    <= RST_BUSY;
      ptr         <= '0;
    end else begin
      bus.ack  <= ack_nxt;
      bus.busy <= (nxt != IDLE);
      if (owner_ld) bus.owner <= winner;
      if (q_ld) begin
        bus.q       <= bus.wdata[int'(bus.owner) * DATA_W +: DATA_W];
        bus.q_valid <= 1'b1;
      end
      if (ptr_adv) ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: stimulus pushes expected acks into a
// scoreboard queue; a negedge monitor pops and compares each ack it sees.
module tb_shared_reg_arbiter;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] q;
    logic [1:0] owner;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  shared_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(input logic [3:0] a, input logic [7:0] d, input logic [1:0] o, input int c);
    exp_t e;
    e.ack = a; e.q = d; e.owner = o; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ack != 4'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {28'b0, bus.ack}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_vec", {28'b0, bus.ack}, {28'b0, e.ack});
        check("ack_q", {24'b0, bus.q}, {24'b0, e.q});
        check("ack_q_valid", {31'b0, bus.q_valid}, 32'h1);
        check("ack_owner", {30'b0, bus.owner}, {30'b0, e.owner});
        check("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rst = 1'b1;
    bus.req = 4'($urandom);
    bus.wdata = 32'($urandom);
    tick();
    tick();
    check("rst_q", {24'b0, bus.q}, 32'h0);
    check("rst_q_valid", {31'b0, bus.q_valid}, 32'h0);
    check("rst_ack", {28'b0, bus.ack}, 32'h0);
    check("rst_owner", {30'b0, bus.owner}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    rst = 1'b0;
    bus.req = '0;
    tick();
    check("post_rst_idle", {31'b0, bus.busy}, 32'h0);

    // Single write from requester 1.
    bus.wdata = {8'h00, 8'h00, 8'hA5, 8'h00};
    bus.req = 4'b0010;
    expect_ack(4'b0010, 8'hA5, 2'd1, cyc + 2);
    tick();
    check("single_owner", {30'b0, bus.owner}, 32'h1);
    check("single_busy_grant", {31'b0, bus.busy}, 32'h1);
    check("single_no_early_ack", {28'b0, bus.ack}, 32'h0);
    tick();
    check("single_busy_ack", {31'b0, bus.busy}, 32'h1);
    bus.req = '0;
    tick();
    check("single_ack_cleared", {28'b0, bus.ack}, 32'h0);
    check("single_busy_done", {31'b0, bus.busy}, 32'h0);
    check("single_q_hold", {24'b0, bus.q}, 32'hA5);

    // Fairness with all four requesters held.
    do_reset();
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 4'b1111;
    c0 = cyc;
    expect_ack(4'b0001, 8'h10, 2'd0, c0 + 2);
    expect_ack(4'b0010, 8'h11, 2'd1, c0 + 5);
    expect_ack(4'b0100, 8'h12, 2'd2, c0 + 8);
    expect_ack(4'b1000, 8'h13, 2'd3, c0 + 11);
    expect_ack(4'b0001, 8'h10, 2'd0, c0 + 14);
    wait_until(c0 + 14);
    bus.req = '0;
    tick();

    // Grant to 3 so q_valid is set before the abort.
    do_reset();
    bus.wdata = {8'h33, 8'h22, 8'h11, 8'hC3};
    bus.req = 4'b1000;
    expect_ack(4'b1000, 8'h33, 2'd3, cyc + 2);
    tick();
    tick();
    bus.req = '0;
    tick();

    // Abort: requester 2 drops during GRANT.
    bus.req = 4'b0100;
    tick();
    check("abort_owner", {30'b0, bus.owner}, 32'h2);
    check("abort_busy_grant", {31'b0, bus.busy}, 32'h1);
    bus.req = '0;
    tick();
    check("abort_idle", {31'b0, bus.busy}, 32'h0);
    check("abort_no_ack", {28'b0, bus.ack}, 32'h0);
    check("abort_q_kept", {24'b0, bus.q}, 32'h33);
    check("abort_q_valid_kept", {31'b0, bus.q_valid}, 32'h1);
    bus.req = 4'b0101;
    expect_ack(4'b0001, 8'hC3, 2'd0, cyc + 2);
    tick();
    tick();
    bus.req = '0;
    tick();

    // Wrap-around: grant 3, then 1001 goes to 0 first, then 3.
    bus.req = 4'b1000;
    expect_ack(4'b1000, 8'h33, 2'd3, cyc + 2);
    tick();
    tick();
    bus.req = '0;
    tick();
    bus.req = 4'b1001;
    c0 = cyc;
    expect_ack(4'b0001, 8'hC3, 2'd0, c0 + 2);
    expect_ack(4'b1000, 8'h33, 2'd3, c0 + 5);
    wait_until(c0 + 5);
    bus.req = '0;
    tick();

    // Reset during GRANT of requester 0.
    bus.wdata = {8'h33, 8'h22, 8'h11, 8'h5A};
    bus.req = 4'b0001;
    tick();
    check("midrst_busy_grant", {31'b0, bus.busy}, 32'h1);
    check("midrst_owner", {30'b0, bus.owner}, 32'h0);
    rst = 1'b1;
    tick();
    check("midrst_ack", {28'b0, bus.ack}, 32'h0);
    check("midrst_q", {24'b0, bus.q}, 32'h0);
    check("midrst_q_valid", {31'b0, bus.q_valid}, 32'h0);
    check("midrst_busy", {31'b0, bus.busy}, 32'h0);
    rst = 1'b0;
    bus.req = '0;
    tick();
    check("midrst_after_ack", {28'b0, bus.ack}, 32'h0);
    check("midrst_after_busy", {31'b0, bus.busy}, 32'h0);
    tick();
    tick();

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
